// File: rtl/uart_receiver_if.sv
// Serial receive bus: the line into the receiver and the byte/status outputs.
`timescale 1ns/1ps
interface uart_receiver_if;
  logic       bit_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       active_o;

  modport master (
    output bit_i,
    input  data_o, valid_o, frame_err_o, active_o
  );

  modport slave (
    input  bit_i,
    output data_o, valid_o, frame_err_o, active_o
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronised line, start-bit validation at mid-bit,
// LSB-first data sampling, stop-bit check with valid / framing-error pulses.
`timescale 1ns/1ps
module uart_receiver #(
  parameter logic [12:0] CLKS_PER_BIT = 13'd1736
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_receiver_if.slave bus
);

  localparam logic [12:0] HALF_LAST = CLKS_PER_BIT / 13'd2 - 13'd1;
  localparam logic [12:0] BIT_LAST  = CLKS_PER_BIT - 13'd1;

  typedef enum logic [2:0] {IDLE, START_B, DATA, STOP_B, CLEANUP} state_t;

  state_t      state, state_n;
  logic        sync1, rx, rx_q;
  logic [1:0]  settle;
  logic        armed;
  logic [12:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_buf;
  logic [7:0]  data_q;
  logic        valid_q, err_q, active_q;
  logic        bit_done, stop_ok, stop_bad;

  assign bit_done = (cnt == BIT_LAST);
  assign stop_ok  = (state == STOP_B) && bit_done && rx;
  assign stop_bad = (state == STOP_B) && bit_done && !rx;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx    <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      sync1 <= bus.bit_i;
      rx    <= sync1;
      rx_q  <= rx;
    end
  end

  // Start detection is armed only once the flushed line has been seen high,
  // so a low line present when reset releases cannot fake a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      if (settle != 2'd3) settle <= settle + 2'd1;
      if (settle == 2'd3 && rx && rx_q) armed <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (armed && rx_q && !rx) state_n = START_B;
      START_B: if (cnt == HALF_LAST) state_n = rx ? IDLE : DATA;
      DATA:    if (bit_done && bit_idx == 3'd7) state_n = STOP_B;
      STOP_B:  if (bit_done) state_n = CLEANUP;
      CLEANUP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bit-period counter, bit index and shift buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shift_buf <= '0;
    end else begin
      if (state == DATA && bit_done) shift_buf[bit_idx] <= rx;
      if (state_n != state) begin
        cnt     <= '0;
        bit_idx <= '0;
      end else if (state == DATA && bit_done) begin
        cnt     <= '0;
        bit_idx <= bit_idx + 3'd1;
      end else if (state != IDLE && state != CLEANUP) begin
        cnt <= cnt + 13'd1;
      end
    end
  end

  // Registered outputs: byte latch, status pulses and frame-active flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      if (stop_ok) data_q <= shift_buf;
      valid_q  <= stop_ok;
      err_q    <= stop_bad;
      active_q <= (state_n == START_B) || (state_n == DATA) || (state_n == STOP_B);
    end
  end

  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.frame_err_o = err_q;
  assign bus.active_o    = active_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: random and directed frames against
// a frame-level reference model (expected byte, outcome and latency).
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int C  = 16;
  localparam int CD = 1736;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic line_a = 1'b1;
  logic line_b = 1'b1;
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  int         va_cyc[$];
  logic [7:0] va_dat[$];
  int         ea_n, both_hi, run, max_run;
  int         vb_cyc[$];
  logic [7:0] vb_dat[$];
  int         eb_n;
  logic [7:0] exp_data;

  uart_receiver_if bus_a ();
  uart_receiver_if bus_b ();
  assign bus_a.bit_i = line_a;
  assign bus_b.bit_i = line_b;

  uart_receiver #(.CLKS_PER_BIT(13'd16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  uart_receiver dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus_a.valid_o) begin
      va_cyc.push_back(cyc);
      va_dat.push_back(bus_a.data_o);
    end
    if (bus_a.frame_err_o) ea_n++;
    if (bus_a.valid_o && bus_a.frame_err_o) both_hi++;
    if (bus_a.active_o) begin
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (bus_b.valid_o) begin
      vb_cyc.push_back(cyc);
      vb_dat.push_back(bus_b.data_o);
    end
    if (bus_b.frame_err_o) eb_n++;
  end

  function automatic int lat_of(input int cpb);
    return 2 + cpb / 2 + 9 * cpb + 1;
  endfunction

  task automatic drive(input bit sel, input logic v);
    if (sel) line_b = v;
    else     line_a = v;
  endtask

  task automatic clear_mon();
    va_cyc.delete();
    va_dat.delete();
    vb_cyc.delete();
    vb_dat.delete();
    ea_n    = 0;
    eb_n    = 0;
    max_run = 0;
  endtask

  // Call just after a rising edge; returns on a rising edge after the stop bit.
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop,
                            input int cpb, output int fall);
    #2;
    fall = cyc;
    drive(sel, 1'b0);
    repeat (cpb) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #2;
      drive(sel, d[i]);
      repeat (cpb) @(posedge clk);
    end
    #2;
    drive(sel, stop);
    repeat (cpb) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus_a.data_o !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", bus_a.data_o); end
    n_vec++; if (bus_a.valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus_a.valid_o); end
    n_vec++; if (bus_a.frame_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", bus_a.frame_err_o); end
    n_vec++; if (bus_a.active_o !== 1'b0) begin n_err++; $display("FAIL reset_active got %b want 0", bus_a.active_o); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    exp_data = 8'h00;
  endtask

  task automatic test_single();
    int fall, lat;
    clear_mon();
    @(posedge clk);
    send_frame(1'b0, 8'hA5, 1'b1, C, fall);
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (va_cyc.size() != 1) begin
      n_err++; $display("FAIL single_count got %0d want 1", va_cyc.size());
    end else begin
      lat = va_cyc[0] - fall;
      n_vec++; if (va_dat[0] !== 8'hA5) begin n_err++; $display("FAIL single_data got %h want a5", va_dat[0]); end
      n_vec++; if (lat < lat_of(C) - 1 || lat > lat_of(C) + 1) begin n_err++; $display("FAIL single_latency got %0d want %0d", lat, lat_of(C)); end
    end
    n_vec++; if (ea_n != 0) begin n_err++; $display("FAIL single_err got %0d want 0", ea_n); end
    n_vec++; if (max_run < 9 * C + C / 2 - 2 || max_run > 9 * C + C / 2 + 2) begin n_err++; $display("FAIL single_active got %0d want %0d", max_run, 9 * C + C / 2); end
    n_vec++; if (bus_a.data_o !== 8'hA5) begin n_err++; $display("FAIL single_hold got %h want a5", bus_a.data_o); end
    exp_data = 8'hA5;
  endtask

  task automatic test_random();
    int fall, lat;
    logic [7:0] d;
    logic stop;
    for (int k = 0; k < 6; k++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      clear_mon();
      @(posedge clk);
      send_frame(1'b0, d, stop, C, fall);
      if (!stop) begin #2 line_a = 1'b1; end
      repeat ($urandom_range(5, 30)) @(posedge clk);
      @(negedge clk);
      if (stop) begin
        exp_data = d;
        n_vec++;
        if (va_cyc.size() != 1) begin
          n_err++; $display("FAIL rand_count k=%0d got %0d want 1", k, va_cyc.size());
        end else begin
          lat = va_cyc[0] - fall;
          n_vec++; if (va_dat[0] !== d) begin n_err++; $display("FAIL rand_data k=%0d got %h want %h", k, va_dat[0], d); end
          n_vec++; if (lat < lat_of(C) - 1 || lat > lat_of(C) + 1) begin n_err++; $display("FAIL rand_latency k=%0d got %0d want %0d", k, lat, lat_of(C)); end
        end
        n_vec++; if (ea_n != 0) begin n_err++; $display("FAIL rand_err k=%0d got %0d want 0", k, ea_n); end
      end else begin
        n_vec++; if (va_cyc.size() != 0) begin n_err++; $display("FAIL rand_badstop_valid k=%0d got %0d want 0", k, va_cyc.size()); end
        n_vec++; if (ea_n != 1) begin n_err++; $display("FAIL rand_badstop_err k=%0d got %0d want 1", k, ea_n); end
      end
      n_vec++; if (bus_a.data_o !== exp_data) begin n_err++; $display("FAIL rand_hold k=%0d got %h want %h", k, bus_a.data_o, exp_data); end
    end
  endtask

  task automatic test_back_to_back();
    int f1, f2;
    clear_mon();
    @(posedge clk);
    send_frame(1'b0, 8'h3C, 1'b1, C, f1);
    send_frame(1'b0, 8'hFF, 1'b1, C, f2);
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (va_cyc.size() != 2) begin
      n_err++; $display("FAIL b2b_count got %0d want 2", va_cyc.size());
    end else begin
      n_vec++; if (va_dat[0] !== 8'h3C) begin n_err++; $display("FAIL b2b_first got %h want 3c", va_dat[0]); end
      n_vec++; if (va_dat[1] !== 8'hFF) begin n_err++; $display("FAIL b2b_second got %h want ff", va_dat[1]); end
      n_vec++;
      if (va_cyc[1] - va_cyc[0] < 10 * C - 1 || va_cyc[1] - va_cyc[0] > 10 * C + 1) begin
        n_err++; $display("FAIL b2b_spacing got %0d want %0d", va_cyc[1] - va_cyc[0], 10 * C);
      end
    end
    n_vec++; if (ea_n != 0) begin n_err++; $display("FAIL b2b_err got %0d want 0", ea_n); end
    exp_data = 8'hFF;
  endtask

  task automatic test_frame_err();
    int fall;
    clear_mon();
    @(posedge clk);
    send_frame(1'b0, 8'h55, 1'b0, C, fall);
    repeat (3 * C) @(posedge clk);
    #2 line_a = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_vec++; if (ea_n != 1) begin n_err++; $display("FAIL ferr_count got %0d want 1", ea_n); end
    n_vec++; if (va_cyc.size() != 0) begin n_err++; $display("FAIL ferr_valid got %0d want 0", va_cyc.size()); end
    n_vec++; if (bus_a.data_o !== exp_data) begin n_err++; $display("FAIL ferr_hold got %h want %h", bus_a.data_o, exp_data); end
  endtask

  task automatic test_glitch();
    clear_mon();
    @(posedge clk);
    #2 line_a = 1'b0;
    repeat (4) @(posedge clk);
    #2 line_a = 1'b1;
    repeat (3 * C) @(posedge clk);
    @(negedge clk);
    n_vec++; if (va_cyc.size() != 0) begin n_err++; $display("FAIL glitch_valid got %0d want 0", va_cyc.size()); end
    n_vec++; if (ea_n != 0) begin n_err++; $display("FAIL glitch_err got %0d want 0", ea_n); end
    n_vec++; if (max_run < 1 || max_run > 9) begin n_err++; $display("FAIL glitch_active got %0d want 1..9", max_run); end
    n_vec++; if (bus_a.data_o !== exp_data) begin n_err++; $display("FAIL glitch_hold got %h want %h", bus_a.data_o, exp_data); end
  endtask

  task automatic test_reset_mid();
    int fall;
    logic [7:0] d;
    d = 8'h81;
    clear_mon();
    @(posedge clk);
    #2 line_a = 1'b0;
    repeat (C) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #2 line_a = d[i];
      repeat (C) @(posedge clk);
    end
    #2 line_a = d[4];
    repeat (C / 2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus_a.data_o !== 8'h00) begin n_err++; $display("FAIL rstmid_data got %h want 00", bus_a.data_o); end
    n_vec++; if (bus_a.active_o !== 1'b0) begin n_err++; $display("FAIL rstmid_active got %b want 0", bus_a.active_o); end
    exp_data = 8'h00;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (C / 2 - 4) @(posedge clk);
    for (int i = 5; i < 8; i++) begin
      #2 line_a = d[i];
      repeat (C) @(posedge clk);
    end
    #2 line_a = 1'b1;
    repeat (C + 20) @(posedge clk);
    @(negedge clk);
    n_vec++; if (va_cyc.size() != 0) begin n_err++; $display("FAIL rstmid_valid got %0d want 0", va_cyc.size()); end
    n_vec++; if (ea_n != 0) begin n_err++; $display("FAIL rstmid_err got %0d want 0", ea_n); end
    clear_mon();
    @(posedge clk);
    send_frame(1'b0, 8'h42, 1'b1, C, fall);
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (va_cyc.size() != 1) begin
      n_err++; $display("FAIL rstmid_next_count got %0d want 1", va_cyc.size());
    end else begin
      n_vec++; if (va_dat[0] !== 8'h42) begin n_err++; $display("FAIL rstmid_next_data got %h want 42", va_dat[0]); end
    end
    n_vec++; if (ea_n != 0) begin n_err++; $display("FAIL rstmid_next_err got %0d want 0", ea_n); end
    exp_data = 8'h42;
  endtask

  task automatic test_default();
    int fall, lat;
    clear_mon();
    @(posedge clk);
    send_frame(1'b1, 8'h00, 1'b1, CD, fall);
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (vb_cyc.size() != 1) begin
      n_err++; $display("FAIL dflt_count got %0d want 1", vb_cyc.size());
    end else begin
      lat = vb_cyc[0] - fall;
      n_vec++; if (vb_dat[0] !== 8'h00) begin n_err++; $display("FAIL dflt_data got %h want 00", vb_dat[0]); end
      n_vec++; if (lat < lat_of(CD) - 1 || lat > lat_of(CD) + 1) begin n_err++; $display("FAIL dflt_latency got %0d want %0d", lat, lat_of(CD)); end
    end
    n_vec++; if (eb_n != 0) begin n_err++; $display("FAIL dflt_err got %0d want 0", eb_n); end
  endtask

  task automatic test_exclusive();
    n_vec++; if (both_hi != 0) begin n_err++; $display("FAIL pulse_exclusive got %0d want 0", both_hi); end
  endtask

  initial begin
    ea_n = 0; eb_n = 0; both_hi = 0; run = 0; max_run = 0;
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_default();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
